// File: rtl/width_conv_pkg.sv
// Shared helpers for the width-converting bit FIFO.
//   fill_w  : number of bits needed to hold a fill level of 0..depth_bits.
//   ptr_adv : wrap-add of a bit pointer inside a ring of `depth` bits.
package width_conv_pkg;

    function automatic int fill_w(input int depth_bits);
        return $clog2(depth_bits + 1);
    endfunction

    // ptr and step are both < depth, so a single conditional subtract
    // is enough to bring the sum back into 0..depth-1.
    function automatic logic [31:0] ptr_adv(input logic [31:0] ptr,
                                            input logic [31:0] step,
                                            input logic [31:0] depth);
        logic [31:0] sum;
        sum = ptr + step;
        if (sum >= depth) begin
            return sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bit_ring_mem.sv
// Bit-granular ring storage for width_conv_fifo.
// Words of WR_W bits are written starting at wr_ptr and words of RD_W bits
// are read starting at rd_ptr; both may straddle the DEPTH_BITS-1 -> 0 wrap.
// Ports:
//   clk      : clock, posedge
//   wr_en    : write the word this cycle
//   wr_ptr   : bit index of wr_data[0]
//   wr_data  : WR_W-bit word, bit 0 stored first
//   rd_ptr   : bit index of rd_data[0]
//   rd_data  : RD_W bits starting at rd_ptr (combinational)
module bit_ring_mem
    import width_conv_pkg::*;
#(
    parameter int DEPTH_BITS = 768,
    parameter int WR_W       = 16,
    parameter int RD_W       = 24,
    localparam int PTR_W     = $clog2(DEPTH_BITS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [WR_W-1:0]  wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [RD_W-1:0]  rd_data
);

    logic [DEPTH_BITS-1:0] mem_q;
    logic [DEPTH_BITS-1:0] mem_d;

    // Each written bit lands at its own wrapped address, so a word split
    // across the end of the array needs no special case.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int i = 0; i < WR_W; i++) begin
                mem_d[PTR_W'(ptr_adv(32'(wr_ptr), 32'(i), 32'(DEPTH_BITS)))] = wr_data[i];
            end
        end
    end

    // Storage is data only; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < RD_W; i++) begin
            rd_data[i] = mem_q[PTR_W'(ptr_adv(32'(rd_ptr), 32'(i), 32'(DEPTH_BITS)))];
        end
    end

endmodule

// File: rtl/width_conv_fifo.sv
// Width-converting ring FIFO: accepts WR_W-bit words, emits RD_W-bit words,
// packing bits contiguously with no padding. Show-ahead read port.
// Ports:
//   clk143, reset      : clock and synchronous active-high reset
//   flush              : synchronous empty, error flags kept
//   wr_en, wr_data     : write request and word (bit 0 stored first)
//   wr_ready           : room for a full WR_W-bit word
//   rd_en              : pop request
//   rd_data, rd_valid  : head word (bit 0 oldest), valid when >= RD_W bits held
//   fill_level         : number of bits held
//   buf_hw, buf_lw     : fill >= HW_MARK, fill <= LW_MARK (registered)
//   overflow/underflow : sticky error flags, cleared only by reset
module width_conv_fifo
    import width_conv_pkg::*;
#(
    parameter int WR_W       = 16,
    parameter int RD_W       = 24,
    parameter int DEPTH_BITS = 768,
    parameter int HW_MARK    = 576,
    parameter int LW_MARK    = 192,
    localparam int FW        = fill_w(DEPTH_BITS),
    localparam int PTR_W     = $clog2(DEPTH_BITS)
) (
    input  logic            clk143,
    input  logic            reset,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [WR_W-1:0] wr_data,
    output logic            wr_ready,
    input  logic            rd_en,
    output logic [RD_W-1:0] rd_data,
    output logic            rd_valid,
    output logic [FW-1:0]   fill_level,
    output logic            buf_hw,
    output logic            buf_lw,
    output logic            overflow,
    output logic            underflow
);

    if ((DEPTH_BITS % WR_W) != 0 || (DEPTH_BITS % RD_W) != 0) begin : g_bad_depth
        $error("width_conv_fifo: DEPTH_BITS must be a multiple of WR_W and RD_W");
    end
    if (!(LW_MARK < HW_MARK && HW_MARK <= DEPTH_BITS)) begin : g_bad_marks
        $error("width_conv_fifo: need LW_MARK < HW_MARK <= DEPTH_BITS");
    end

    localparam logic [FW:0]   WR_STEP  = (FW+1)'(WR_W);
    localparam logic [FW:0]   RD_STEP  = (FW+1)'(RD_W);
    localparam logic [FW:0]   HW_C     = (FW+1)'(HW_MARK);
    localparam logic [FW:0]   LW_C     = (FW+1)'(LW_MARK);
    localparam logic [FW-1:0] WR_LIMIT = FW'(DEPTH_BITS - WR_W);
    localparam logic [FW-1:0] RD_MIN   = FW'(RD_W);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             buf_hw_q, buf_hw_d;
    logic             buf_lw_q, buf_lw_d;

    logic             acc_wr;
    logic             acc_rd;
    logic [FW:0]      fill_next;

    // Acceptance is decided from the registered fill only, so a word
    // written into an empty FIFO cannot be popped in the same cycle.
    assign wr_ready = (fill_q <= WR_LIMIT);
    assign rd_valid = (fill_q >= RD_MIN);
    assign acc_wr   = wr_en & wr_ready & ~flush;
    assign acc_rd   = rd_en & rd_valid & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q  | (wr_en & ~wr_ready & ~flush);
        underflow_d = underflow_q | (rd_en & ~rd_valid & ~flush);
        fill_next   = {1'b0, fill_q};

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            fill_next = '0;
        end else begin
            if (acc_wr) begin
                wr_ptr_d  = PTR_W'(ptr_adv(32'(wr_ptr_q), 32'(WR_W), 32'(DEPTH_BITS)));
                fill_next = fill_next + WR_STEP;
            end
            if (acc_rd) begin
                rd_ptr_d  = PTR_W'(ptr_adv(32'(rd_ptr_q), 32'(RD_W), 32'(DEPTH_BITS)));
                fill_next = fill_next - RD_STEP;
            end
        end

        fill_d = fill_next[FW-1:0];
        // Watermarks come from the next fill so they line up with fill_level.
        buf_hw_d = (fill_next >= HW_C);
        buf_lw_d = (fill_next <= LW_C);
    end

    always_ff @(posedge clk143) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            buf_hw_q    <= 1'b0;
            buf_lw_q    <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            buf_hw_q    <= buf_hw_d;
            buf_lw_q    <= buf_lw_d;
        end
    end

    assign fill_level = fill_q;
    assign buf_hw     = buf_hw_q;
    assign buf_lw     = buf_lw_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    bit_ring_mem #(
        .DEPTH_BITS (DEPTH_BITS),
        .WR_W       (WR_W),
        .RD_W       (RD_W)
    ) u_mem (
        .clk     (clk143),
        .wr_en   (acc_wr),
        .wr_ptr  (wr_ptr_q),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr_q),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_width_conv_fifo.sv
// Self-checking bench for width_conv_fifo. The reference model is a plain
// queue of bits: writes append WR_W bits, pops remove RD_W bits from the front.
module tb_width_conv_fifo;

    localparam int WR_W  = 16;
    localparam int RD_W  = 24;
    localparam int DEPTH = 768;
    localparam int HW    = 576;
    localparam int LW    = 192;
    localparam int FW    = 10;

    logic            clk143 = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            wr_en = 1'b0;
    logic [WR_W-1:0] wr_data = '0;
    logic            wr_ready;
    logic            rd_en = 1'b0;
    logic [RD_W-1:0] rd_data;
    logic            rd_valid;
    logic [FW-1:0]   fill_level;
    logic            buf_hw;
    logic            buf_lw;
    logic            overflow;
    logic            underflow;

    always #5 clk143 = ~clk143;

    width_conv_fifo #(
        .WR_W(WR_W), .RD_W(RD_W), .DEPTH_BITS(DEPTH), .HW_MARK(HW), .LW_MARK(LW)
    ) dut (
        .clk143(clk143), .reset(reset), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .fill_level(fill_level), .buf_hw(buf_hw), .buf_lw(buf_lw),
        .overflow(overflow), .underflow(underflow)
    );

    int n_assert = 0;
    int n_fail   = 0;

    bit mq[$];
    bit ovf_m = 1'b0;
    bit udf_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RD_W-1:0] model_head();
        logic [RD_W-1:0] h;
        h = '0;
        for (int k = 0; k < RD_W; k++) begin
            if (k < mq.size()) h[k] = mq[k];
        end
        return h;
    endfunction

    task automatic model_update(input logic r, input logic f, input logic we,
                                input logic [WR_W-1:0] wd, input logic re);
        int pre;
        pre = mq.size();
        if (r) begin
            mq.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else if (f) begin
            mq.delete();
        end else begin
            if (re) begin
                if (pre >= RD_W) begin
                    repeat (RD_W) void'(mq.pop_front());
                end else begin
                    udf_m = 1'b1;
                end
            end
            if (we) begin
                if (pre <= DEPTH - WR_W) begin
                    for (int k = 0; k < WR_W; k++) mq.push_back(wd[k]);
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        check({tag, ".fill"},      32'(fill_level), 32'(sz));
        check({tag, ".rd_valid"},  32'(rd_valid),   32'(sz >= RD_W));
        check({tag, ".wr_ready"},  32'(wr_ready),   32'(sz <= DEPTH - WR_W));
        check({tag, ".buf_hw"},    32'(buf_hw),     32'(sz >= HW));
        check({tag, ".buf_lw"},    32'(buf_lw),     32'(sz <= LW));
        check({tag, ".overflow"},  32'(overflow),   32'(ovf_m));
        check({tag, ".underflow"}, 32'(underflow),  32'(udf_m));
        if (sz >= RD_W) begin
            check({tag, ".rd_data"}, 32'(rd_data), 32'(model_head()));
        end
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input string tag, input logic r, input logic f, input logic we,
                        input logic [WR_W-1:0] wd, input logic re);
        reset   = r;
        flush   = f;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk143);
        #1;
        model_update(r, f, we, wd, re);
        check_all(tag);
    endtask

    initial begin
        logic re;

        // Reset
        step("reset0", 1, 0, 0, 16'h0, 0);
        step("reset1", 1, 0, 0, 16'h0, 0);
        check("reset.fill", 32'(fill_level), 32'd0);
        check("reset.buf_lw", 32'(buf_lw), 32'd1);
        check("reset.wr_ready", 32'(wr_ready), 32'd1);

        // Packing 16 -> 24
        step("pack_w1", 0, 0, 1, 16'h3322, 0);
        check("pack_w1.valid", 32'(rd_valid), 32'd0);
        step("pack_w2", 0, 0, 1, 16'h5544, 0);
        check("pack_w2.valid", 32'(rd_valid), 32'd1);
        check("pack_w2.data", 32'(rd_data), 32'h443322);
        check("pack_w2.fill", 32'(fill_level), 32'd32);
        step("pack_pop", 0, 0, 0, 16'h0, 1);
        check("pack_pop.fill", 32'(fill_level), 32'd8);
        step("pack_w3", 0, 0, 1, 16'h7766, 0);
        check("pack_w3.data", 32'(rd_data), 32'h776655);
        check("pack_w3.fill", 32'(fill_level), 32'd24);
        step("pack_drain", 0, 0, 0, 16'h0, 1);

        // Wrap: stream crosses bit 767 -> 0
        for (int i = 0; i < 47; i++) begin
            re = (mq.size() >= RD_W) && ($urandom_range(0, 1) == 1);
            step("wrap", 0, 0, 1, 16'hA5A5 + 16'(i), re);
        end
        for (int i = 0; i < 40; i++) begin
            if (mq.size() >= RD_W) step("wrap_drain", 0, 0, 0, 16'h0, 1);
        end

        // Random traffic, including occasional flushes and error attempts
        step("rnd_reset", 1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 400; i++) begin
            step("rnd", 0, ($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 60),
                 16'($urandom), ($urandom_range(0, 99) < 45));
        end

        // Full / overflow
        step("full_reset", 1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 48; i++) begin
            step("full", 0, 0, 1, 16'h1000 + 16'(i), 0);
            if (i == 35) check("full.hw_at_576", 32'(buf_hw), 32'd1);
            if (i == 34) check("full.hw_at_560", 32'(buf_hw), 32'd0);
        end
        check("full.fill", 32'(fill_level), 32'd768);
        check("full.wr_ready", 32'(wr_ready), 32'd0);
        check("full.head", 32'(rd_data), 32'h011000);
        step("full_w49", 0, 0, 1, 16'hFFFF, 0);
        check("full_w49.overflow", 32'(overflow), 32'd1);
        check("full_w49.head", 32'(rd_data), 32'h011000);
        check("full_w49.fill", 32'(fill_level), 32'd768);

        // Flush mid-operation keeps overflow
        step("flush_full", 0, 1, 0, 16'h0, 0);
        for (int i = 0; i < 14; i++) step("fill200", 0, 0, 1, 16'h2000 + 16'(i), 0);
        step("fill200_pop", 0, 0, 0, 16'h0, 1);
        check("fill200.fill", 32'(fill_level), 32'd200);
        step("flush_wr", 0, 1, 1, 16'hDEAD, 1);
        check("flush_wr.fill", 32'(fill_level), 32'd0);
        check("flush_wr.buf_lw", 32'(buf_lw), 32'd1);
        check("flush_wr.overflow", 32'(overflow), 32'd1);
        check("flush_wr.underflow", 32'(underflow), 32'd0);

        // Reset with overflow set
        step("rst_ovf", 1, 0, 0, 16'h0, 0);
        check("rst_ovf.overflow", 32'(overflow), 32'd0);
        check("rst_ovf.buf_hw", 32'(buf_hw), 32'd0);
        check("rst_ovf.buf_lw", 32'(buf_lw), 32'd1);
        check("rst_ovf.rd_valid", 32'(rd_valid), 32'd0);
        check("rst_ovf.wr_ready", 32'(wr_ready), 32'd1);

        // Empty / underflow, then residual bits
        step("udf_pop", 0, 0, 0, 16'h0, 1);
        check("udf_pop.underflow", 32'(underflow), 32'd1);
        check("udf_pop.fill", 32'(fill_level), 32'd0);
        step("udf_w1", 0, 0, 1, 16'h1234, 0);
        check("udf_w1.rd_valid", 32'(rd_valid), 32'd0);
        check("udf_w1.fill", 32'(fill_level), 32'd16);
        check("udf_w1.buf_lw", 32'(buf_lw), 32'd1);

        // Simultaneous write and pop
        step("sim_reset", 1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) step("sim_fill", 0, 0, 1, 16'hB000 + 16'(i), 0);
        check("sim_fill.fill", 32'(fill_level), 32'd48);
        step("sim1", 0, 0, 1, 16'hC001, 1);
        check("sim1.fill", 32'(fill_level), 32'd40);
        step("sim2", 0, 0, 1, 16'hC002, 1);
        check("sim2.fill", 32'(fill_level), 32'd32);
        step("sim3", 0, 0, 1, 16'hC003, 1);
        check("sim3.fill", 32'(fill_level), 32'd24);
        step("sim4", 0, 0, 1, 16'hC004, 1);
        check("sim4.fill", 32'(fill_level), 32'd16);
        check("sim4.rd_valid", 32'(rd_valid), 32'd0);
        check("sim4.underflow", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/width_conv_fifo.md
Name: width_conv_fifo

Overview:
- Parametrised width-converting ring buffer for the audio/sample path: accepts WR_W-bit words, emits RD_W-bit words.
- Storage is bit-granular, so words of one width pack contiguously into words of the other, with no padding.
- Sits between a producer (e.g. SDRAM/bus burst, 16-bit) and a consumer (e.g. 24-bit sample sink).
- Adds over the previous generation: explicit ready/valid handshake, bit-exact fill level, sticky overflow/underflow flags, synchronous flush, and watermark flags driven from a single fill counter.

Parameters:
- WR_W, 16, write word width in bits (>=1).
- RD_W, 24, read word width in bits (>=1).
- DEPTH_BITS, 768, capacity in bits. Must be a multiple of both WR_W and RD_W; elaboration-time assertion.
- HW_MARK, 576, high watermark in bits, LW_MARK < HW_MARK <= DEPTH_BITS.
- LW_MARK, 192, low watermark in bits.

Ports:
- clk143, input, 1, system clock; all logic on posedge.
- reset, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous empty; error flags are kept.
- wr_en, input, 1, write request.
- wr_data, input, WR_W, write word; bit 0 is stored first.
- wr_ready, output, 1, a write of WR_W bits will be accepted this cycle.
- rd_en, input, 1, pop request.
- rd_data, output, RD_W, head word, show-ahead; bit 0 is oldest.
- rd_valid, output, 1, at least RD_W bits held.
- fill_level, output, clog2(DEPTH_BITS+1), bits currently stored.
- buf_hw, output, 1, fill_level >= HW_MARK.
- buf_lw, output, 1, fill_level <= LW_MARK.
- overflow, output, 1, sticky: a write was attempted while wr_ready=0.
- underflow, output, 1, sticky: a pop was attempted while rd_valid=0.

Behaviour:
- Reset (clk143 edge with reset=1):
  - wr_ptr=0, rd_ptr=0, fill=0.
  - overflow=0, underflow=0, buf_hw=0, buf_lw=1.
  - rd_valid=0, wr_ready=1. Storage contents are don't-care.
  - reset has priority over every other input.
- Pointers are bit indices in 0..DEPTH_BITS-1 and wrap modulo DEPTH_BITS.
  - A word may straddle the wrap point; bit i of a word lives at (ptr+i) mod DEPTH_BITS.
  - Pointer advance: if ptr+W >= DEPTH_BITS then ptr+W-DEPTH_BITS, else ptr+W. No `%` operator.
- Write and read acceptance:
  - wr_ready = (fill <= DEPTH_BITS-WR_W), combinational from registered fill.
  - rd_valid = (fill >= RD_W), combinational from registered fill.
  - Write accepted iff wr_en & wr_ready: store wr_data, advance wr_ptr by WR_W.
  - Pop accepted iff rd_en & rd_valid: advance rd_ptr by RD_W.
- Simultaneous accepted write and pop: both take effect.
  - fill_next = fill + WR_W*acc_wr - RD_W*acc_rd, computed one bit wider than fill_level.
  - Acceptance is judged on the pre-edge fill. There is no pass-through: a write into an empty FIFO does not make rd_valid true in the same cycle.
- rd_data is a combinational read of the RD_W bits at rd_ptr. It is don't-care while rd_valid=0.
- Latency:
  - An accepted write is visible in fill_level, rd_valid and rd_data on the next cycle.
  - After an accepted pop, the next head word appears on the next cycle.
- Errors:
  - wr_en & !wr_ready: data dropped, pointers unchanged, overflow<=1.
  - rd_en & !rd_valid: no pop, underflow<=1.
  - Both flags are sticky until reset.
- flush: wr_ptr, rd_ptr and fill <= 0, watermarks recomputed as for fill=0. Any write or pop in the same cycle is ignored and does not set error flags.
- Watermarks are registered from fill_next, so they track fill_level in the same cycle.
  - Both flags are evaluated independently; no hysteresis.
- Residual bits: when fill < RD_W the remaining bits are retained and are not lost. They become readable once enough writes arrive.

Decomposition:
- Package width_conv_pkg:
  - function ptr_adv(ptr, step, depth) implementing the wrap-add above.
  - localparam-style helper for the fill width.
- Sub-module bit_ring_mem (DEPTH_BITS, WR_W, RD_W):
  - flop-based bit array.
  - write port: wr_en, wr_ptr, wr_data; per-bit wrapped write enable.
  - read port: rd_ptr in, rd_data out; combinational wrapped read.
- Pointer, fill and flag logic stays in width_conv_fifo.

Test Plan:
- Packing: after reset, write 16'h3322, 16'h5544, 16'h7766 on consecutive cycles.
  - rd_valid rises the cycle after the 2nd write, with rd_data=24'h443322 and fill_level=32.
  - Pop, then after the 3rd write: rd_data=24'h776655 and fill_level=24.
- Wrap straddle: 47 writes of 16'hA5A5+i interleaved with pops.
  - Words crossing bit 767→0 read back bit-exact against a reference queue model.
  - fill_level matches the model every cycle.
- Full/overflow: 48 back-to-back writes with no pops.
  - fill_level=768, wr_ready=0, buf_hw=1 from fill 576 onward.
  - 49th write is dropped; overflow=1; rd_data is unchanged.
- Empty/underflow: pop on an empty FIFO → underflow=1, fill_level=0.
  - Then write one 16-bit word: rd_valid stays 0, fill_level=16, buf_lw=1.
- Simultaneous: hold fill=48 and assert wr_en and rd_en together → fill_level=40 next cycle.
  - Repeat until fill < 24: rd_valid drops with no underflow.
- Flush/reset mid-operation:
  - flush at fill=200 together with wr_en → fill_level=0, buf_lw=1, overflow unchanged.
  - reset asserted with overflow=1 → all outputs return to their reset values.
